// File: rtl/axi_wr_burst_gen_if.sv
// rtl/axi_wr_burst_gen_if.sv - AXI4 write-channel bundle (AW/W/B) for the burst generator
interface axi_wr_burst_gen_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 10,
    parameter int UW = 8
);
    logic [IW-1:0]   aw_id;
    logic [AW-1:0]   aw_addr;
    logic [7:0]      aw_len;
    logic [2:0]      aw_size;
    logic [1:0]      aw_burst;
    logic [UW-1:0]   aw_user;
    logic            aw_valid;
    logic            aw_ready;

    logic [DW-1:0]   w_data;
    logic [DW/8-1:0] w_strb;
    logic            w_last;
    logic [UW-1:0]   w_user;
    logic            w_valid;
    logic            w_ready;

    logic [IW-1:0]   b_id;
    logic [1:0]      b_resp;
    logic [UW-1:0]   b_user;
    logic            b_valid;
    logic            b_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready
    );
endinterface

// File: rtl/axi_wr_burst_gen.sv
// rtl/axi_wr_burst_gen.sv - AXI4 INCR write burst generator with bounded outstanding and B checking
module axi_wr_burst_gen #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int IW        = 10,
    parameter int UW        = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [15:0]   num_txn_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [7:0]    len_i,
    input  logic [IW-1:0] id_i,
    input  logic [UW-1:0] user_i,
    input  logic [DW-1:0] data_seed_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [15:0]   err_cnt_o,
    output logic [1:0]    last_resp_o,
    axi_wr_burst_gen_if.master m_axi
);
    localparam int SIZE = $clog2(DW/8);
    localparam int OW   = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTST);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t r_state, w_state_nxt;

    logic [15:0]     r_num_txn;
    logic [7:0]      r_len;
    logic [IW-1:0]   r_id;

    logic [15:0]     r_aw_sent;
    logic [OW-1:0]   r_outst;
    logic [15:0]     r_b_cnt;
    logic [7:0]      r_w_beat;
    logic [15:0]     r_w_burst;

    logic [IW-1:0]   r_aw_id;
    logic [AW-1:0]   r_aw_addr;
    logic [7:0]      r_aw_len;
    logic [2:0]      r_aw_size;
    logic [1:0]      r_aw_burst;
    logic [UW-1:0]   r_aw_user;
    logic            r_aw_valid;

    logic [DW-1:0]   r_w_data;
    logic [DW/8-1:0] r_w_strb;
    logic            r_w_last;
    logic [UW-1:0]   r_w_user;
    logic            r_w_valid;

    logic            r_b_ready;
    logic [15:0]     r_err_cnt;
    logic [1:0]      r_last_resp;

    logic            w_run;
    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_b_hs;
    logic            w_b_counted;
    logic            w_b_bad;
    logic [15:0]     w_aw_sent_nxt;
    logic [OW-1:0]   w_outst_nxt;
    logic [16:0]     w_b_cnt_nxt;
    logic            w_beat_is_last;
    logic [7:0]      w_w_beat_nxt;
    logic [15:0]     w_w_burst_nxt;
    logic [AW-1:0]   w_burst_bytes;
    logic            w_unused_b_user;

    assign w_run   = (r_state == S_RUN);
    assign w_aw_hs = r_aw_valid & m_axi.aw_ready;
    assign w_w_hs  = r_w_valid & m_axi.w_ready;
    assign w_b_hs  = m_axi.b_valid & r_b_ready;

    // Only a B that matches an in-flight AW counts towards completion; anything else is an error.
    assign w_b_counted = w_b_hs & w_run & (r_outst != '0);
    assign w_b_bad     = (m_axi.b_resp != 2'b00) | (m_axi.b_id != r_id) | ~w_b_counted;

    assign w_aw_sent_nxt = r_aw_sent + 16'(w_aw_hs);
    assign w_b_cnt_nxt   = {1'b0, r_b_cnt} + 17'(w_b_counted);

    always_comb begin
        w_outst_nxt = r_outst;
        if (w_aw_hs && !w_b_counted) begin
            w_outst_nxt = r_outst + OW'(1);
        end else if (!w_aw_hs && w_b_counted) begin
            w_outst_nxt = r_outst - OW'(1);
        end
    end

    assign w_beat_is_last = (r_w_beat == r_len);
    assign w_w_beat_nxt   = !w_w_hs ? r_w_beat : (w_beat_is_last ? 8'd0 : r_w_beat + 8'd1);
    assign w_w_burst_nxt  = r_w_burst + 16'(w_w_hs & w_beat_is_last);

    assign w_burst_bytes = AW'({1'b0, r_len} + 9'd1) << SIZE;

    assign w_unused_b_user = ^m_axi.b_user;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_state_nxt = S_RUN;
            S_RUN:  if (w_b_cnt_nxt == {1'b0, r_num_txn}) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_num_txn   <= '0;
            r_len       <= '0;
            r_id        <= '0;
            r_aw_sent   <= '0;
            r_outst     <= '0;
            r_b_cnt     <= '0;
            r_w_beat    <= '0;
            r_w_burst   <= '0;
            r_aw_id     <= '0;
            r_aw_addr   <= '0;
            r_aw_len    <= '0;
            r_aw_size   <= '0;
            r_aw_burst  <= '0;
            r_aw_user   <= '0;
            r_aw_valid  <= 1'b0;
            r_w_data    <= '0;
            r_w_strb    <= '0;
            r_w_last    <= 1'b0;
            r_w_user    <= '0;
            r_w_valid   <= 1'b0;
            r_b_ready   <= 1'b0;
            r_err_cnt   <= '0;
            r_last_resp <= '0;
        end else begin
            r_b_ready <= 1'b1;
            if (r_state == S_IDLE && start_i) begin
                r_num_txn   <= num_txn_i;
                r_len       <= len_i;
                r_id        <= id_i;
                r_aw_sent   <= '0;
                r_outst     <= '0;
                r_b_cnt     <= '0;
                r_w_beat    <= '0;
                r_w_burst   <= '0;
                r_aw_id     <= id_i;
                r_aw_addr   <= base_addr_i;
                r_aw_len    <= len_i;
                r_aw_size   <= 3'(SIZE);
                r_aw_burst  <= 2'b01;
                r_aw_user   <= user_i;
                r_aw_valid  <= (num_txn_i != 16'd0);
                r_w_data    <= data_seed_i;
                r_w_strb    <= '1;
                r_w_last    <= (len_i == 8'd0);
                r_w_user    <= user_i;
                r_w_valid   <= 1'b0;
                r_err_cnt   <= '0;
                r_last_resp <= '0;
            end else begin
                if (w_b_hs && w_b_bad && r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                if (w_b_hs && w_run) begin
                    r_last_resp <= m_axi.b_resp;
                end

                if (w_run) begin
                    r_aw_sent <= w_aw_sent_nxt;
                    r_outst   <= w_outst_nxt;
                    r_b_cnt   <= w_b_cnt_nxt[15:0];
                    r_w_beat  <= w_w_beat_nxt;
                    r_w_burst <= w_w_burst_nxt;

                    if (w_aw_hs) begin
                        r_aw_addr <= r_aw_addr + w_burst_bytes;
                    end
                    // Valid re-evaluated only when idle or just accepted, so it never drops unacknowledged.
                    if (!r_aw_valid || w_aw_hs) begin
                        r_aw_valid <= (w_aw_sent_nxt != r_num_txn) && (w_outst_nxt < MAX_O);
                    end

                    if (w_w_hs) begin
                        r_w_data <= r_w_data + DW'(1);
                        r_w_last <= (w_w_beat_nxt == r_len);
                    end
                    // A burst's beats may only start once its AW has been accepted.
                    if (!r_w_valid || w_w_hs) begin
                        r_w_valid <= (w_w_burst_nxt < r_num_txn) && (w_w_burst_nxt < w_aw_sent_nxt);
                    end
                end else begin
                    r_aw_valid <= 1'b0;
                    r_w_valid  <= 1'b0;
                end
            end
        end
    end

    assign busy_o      = w_run;
    assign done_o      = (r_state == S_DONE);
    assign err_cnt_o   = r_err_cnt;
    assign last_resp_o = r_last_resp;

    assign m_axi.aw_id    = r_aw_id;
    assign m_axi.aw_addr  = r_aw_addr;
    assign m_axi.aw_len   = r_aw_len;
    assign m_axi.aw_size  = r_aw_size;
    assign m_axi.aw_burst = r_aw_burst;
    assign m_axi.aw_user  = r_aw_user;
    assign m_axi.aw_valid = r_aw_valid;
    assign m_axi.w_data   = r_w_data;
    assign m_axi.w_strb   = r_w_strb;
    assign m_axi.w_last   = r_w_last;
    assign m_axi.w_user   = r_w_user;
    assign m_axi.w_valid  = r_w_valid;
    assign m_axi.b_ready  = r_b_ready;
endmodule

// File: tb/tb_axi_wr_burst_gen.sv
// tb/tb_axi_wr_burst_gen.sv - randomized self-checking bench for axi_wr_burst_gen
`timescale 1ns/1ps
module tb_axi_wr_burst_gen;
    localparam int AW = 32, DW = 32, IW = 10, UW = 8, MAX_OUTST = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [15:0]   num_txn = '0;
    logic [AW-1:0] base = '0;
    logic [7:0]    len = '0;
    logic [IW-1:0] id = '0;
    logic [UW-1:0] user = '0;
    logic [DW-1:0] seed = '0;
    logic          busy, done;
    logic [15:0]   err_cnt;
    logic [1:0]    last_resp;

    axi_wr_burst_gen_if #(.AW(AW), .DW(DW), .IW(IW), .UW(UW)) bus ();

    axi_wr_burst_gen #(.AW(AW), .DW(DW), .IW(IW), .UW(UW), .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_txn_i(num_txn),
        .base_addr_i(base), .len_i(len), .id_i(id), .user_i(user), .data_seed_i(seed),
        .busy_o(busy), .done_o(done), .err_cnt_o(err_cnt), .last_resp_o(last_resp),
        .m_axi(bus)
    );

    int checks = 0;
    int errors = 0;

    int cyc = 0, cyc0 = 0;
    int aw_rx, wlast_rx, b_rx, stab_viol, order_viol, outst_max, last_b_cyc;
    int aw_pct = 100, w_pct = 100, b_release = 0, bad_resp_idx = -1, bad_id_idx = -1;
    logic [AW-1:0]        awa_q[$];
    logic [IW+UW+12:0]    awf_q[$];
    int                   awc_q[$];
    logic [DW-1:0]        wd_q[$];
    bit                   wl_q[$];
    logic [DW/8+UW-1:0]   ws_q[$];
    int                   wc_q[$];
    logic [AW+IW+UW+12:0] aw_hold;
    logic [DW+DW/8+UW:0]  w_hold;
    bit                   aw_pend = 0, w_pend = 0;

    int            c_num, c_len;
    logic [AW-1:0] c_base;
    logic [DW-1:0] c_seed;
    logic [IW-1:0] c_id;
    logic [UW-1:0] c_user;

    // Slave model and monitor: decides readies and B on the falling edge, records handshakes
    // that will occur on the following rising edge.
    initial begin
        logic [AW+IW+UW+12:0] aw_now;
        logic [DW+DW/8+UW:0]  w_now;
        bit rdy;
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0;
        bus.b_id = '0; bus.b_resp = '0; bus.b_user = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0;
                aw_pend = 0; w_pend = 0;
            end else begin
                bus.b_valid = 1'b0; bus.b_resp = 2'b00; bus.b_id = '0;
                if (b_rx < aw_rx && b_rx < wlast_rx && cyc >= b_release && bus.b_ready) begin
                    bus.b_valid = 1'b1;
                    bus.b_id    = (b_rx == bad_id_idx) ? (c_id ^ IW'(1)) : c_id;
                    bus.b_resp  = (b_rx == bad_resp_idx) ? 2'b10 : 2'b00;
                    b_rx++;
                    last_b_cyc = cyc;
                end

                w_now = {bus.w_data, bus.w_strb, bus.w_last, bus.w_user};
                if (w_pend && (!bus.w_valid || w_now !== w_hold)) stab_viol++;
                if (bus.w_valid && !w_pend && wlast_rx >= aw_rx) order_viol++;
                rdy = (int'($urandom_range(99)) < w_pct);
                bus.w_ready = rdy;
                if (bus.w_valid && rdy) begin
                    wd_q.push_back(bus.w_data);
                    wl_q.push_back(bus.w_last);
                    ws_q.push_back({bus.w_strb, bus.w_user});
                    wc_q.push_back(cyc);
                    if (bus.w_last) wlast_rx++;
                    w_pend = 0;
                end else begin
                    w_pend = bus.w_valid;
                    w_hold = w_now;
                end

                aw_now = {bus.aw_addr, bus.aw_id, bus.aw_len, bus.aw_size, bus.aw_burst, bus.aw_user};
                if (aw_pend && (!bus.aw_valid || aw_now !== aw_hold)) stab_viol++;
                rdy = (int'($urandom_range(99)) < aw_pct);
                bus.aw_ready = rdy;
                if (bus.aw_valid && rdy) begin
                    awa_q.push_back(bus.aw_addr);
                    awf_q.push_back({bus.aw_id, bus.aw_len, bus.aw_size, bus.aw_burst, bus.aw_user});
                    awc_q.push_back(cyc);
                    aw_rx++;
                    aw_pend = 0;
                end else begin
                    aw_pend = bus.aw_valid;
                    aw_hold = aw_now;
                end
                if (aw_rx - b_rx > outst_max) outst_max = aw_rx - b_rx;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_sb();
        aw_rx = 0; wlast_rx = 0; b_rx = 0; stab_viol = 0; order_viol = 0;
        outst_max = 0; last_b_cyc = -1;
        awa_q.delete(); awf_q.delete(); awc_q.delete();
        wd_q.delete(); wl_q.delete(); ws_q.delete(); wc_q.delete();
    endtask

    task automatic start_cmd(input int n, input logic [AW-1:0] b, input int l, input logic [DW-1:0] s,
                             input int awp, input int wp, input int hold, input int br, input int bi);
        tick();
        c_num = n; c_base = b; c_len = l; c_seed = s;
        c_id = IW'($urandom); c_user = UW'($urandom);
        num_txn = 16'(n); base = b; len = 8'(l); seed = s; id = c_id; user = c_user;
        aw_pct = awp; w_pct = wp; bad_resp_idx = br; bad_id_idx = bi;
        clear_sb();
        cyc0 = cyc;
        b_release = cyc0 + hold;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_txn = 16'($urandom); base = AW'($urandom); len = 8'($urandom);
        id = IW'($urandom); user = UW'($urandom); seed = DW'($urandom);
        checks++;
        if ({busy, bus.aw_valid} !== {1'b1, n != 0}) begin
            errors++;
            $display("FAIL start_latency: busy/aw_valid=%b expected %b", {busy, bus.aw_valid}, {1'b1, n != 0});
        end
    endtask

    task automatic finish_cmd(input string name);
        int t = 0;
        int exp_cyc, exp_err;
        logic [1:0] exp_resp;
        logic [63:0] a;
        logic [IW+UW+12:0] exp_f;
        logic [DW-1:0] exp_d;
        while (!done && t < 4000) begin
            tick();
            t++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: done=%b expected 1 within 4000 cycles", name, done);
        end else begin
            exp_cyc = (c_num == 0) ? cyc0 + 2 : last_b_cyc + 1;
            checks++;
            if (cyc !== exp_cyc) begin
                errors++;
                $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc - cyc0, exp_cyc - cyc0);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
            end
            exp_err = 0;
            for (int i = 0; i < c_num; i++) if (i == bad_resp_idx || i == bad_id_idx) exp_err++;
            exp_resp = (c_num != 0 && c_num - 1 == bad_resp_idx) ? 2'b10 : 2'b00;
            checks++;
            if (err_cnt !== 16'(exp_err)) begin
                errors++;
                $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, exp_err);
            end
            checks++;
            if (last_resp !== exp_resp) begin
                errors++;
                $display("FAIL %s last_resp: got %0d expected %0d", name, last_resp, exp_resp);
            end
        end
        checks++;
        if (aw_rx !== c_num || b_rx !== c_num || wd_q.size() !== c_num * (c_len + 1)) begin
            errors++;
            $display("FAIL %s counts: aw=%0d b=%0d beats=%0d expected aw=%0d b=%0d beats=%0d",
                     name, aw_rx, b_rx, wd_q.size(), c_num, c_num, c_num * (c_len + 1));
        end
        checks++;
        if (stab_viol !== 0 || order_viol !== 0 || outst_max > MAX_OUTST) begin
            errors++;
            $display("FAIL %s protocol: unstable=%0d w_before_aw=%0d max_outst=%0d expected 0/0/<=%0d",
                     name, stab_viol, order_viol, outst_max, MAX_OUTST);
        end
        for (int k = 0; k < awa_q.size(); k++) begin
            a = 64'(c_base) + 64'(k) * 64'(c_len + 1) * 64'(DW/8);
            exp_f = {c_id, 8'(c_len), 3'($clog2(DW/8)), 2'b01, c_user};
            checks++;
            if (awa_q[k] !== a[AW-1:0] || awf_q[k] !== exp_f) begin
                errors++;
                $display("FAIL %s aw[%0d]: addr=%h fields=%h expected addr=%h fields=%h",
                         name, k, awa_q[k], awf_q[k], a[AW-1:0], exp_f);
            end
        end
        for (int g = 0; g < wd_q.size(); g++) begin
            exp_d = c_seed + DW'(g);
            checks++;
            if (wd_q[g] !== exp_d || wl_q[g] !== ((g % (c_len + 1)) == c_len) || ws_q[g] !== {{(DW/8){1'b1}}, c_user}) begin
                errors++;
                $display("FAIL %s w[%0d]: data=%h last=%b strb_user=%h expected data=%h last=%b strb_user=%h",
                         name, g, wd_q[g], wl_q[g], ws_q[g], exp_d, ((g % (c_len + 1)) == c_len), {{(DW/8){1'b1}}, c_user});
            end
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse_width: got %b expected 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.aw_valid, bus.w_valid, bus.b_ready, busy, done, err_cnt, last_resp, bus.aw_addr, bus.aw_id,
             bus.aw_len, bus.aw_size, bus.aw_burst, bus.aw_user, bus.w_data, bus.w_strb, bus.w_last, bus.w_user} !== '0) begin
            errors++;
            $display("FAIL reset_values: aw_valid=%b w_valid=%b b_ready=%b busy=%b done=%b err=%h aw_addr=%h w_data=%h expected all 0",
                     bus.aw_valid, bus.w_valid, bus.b_ready, busy, done, err_cnt, bus.aw_addr, bus.w_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.b_ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset: b_ready/busy/done=%b expected 100", {bus.b_ready, busy, done});
        end
    endtask

    task automatic test_single();
        start_cmd(1, AW'($urandom), 0, 32'hcafebabe, 100, 100, 0, -1, -1);
        finish_cmd("single");
    endtask

    task automatic test_eight_bursts();
        start_cmd(8, 32'h1000, 3, DW'($urandom), 100, 100, 0, -1, -1);
        finish_cmd("eight");
    endtask

    task automatic test_max_outst();
        start_cmd(8, AW'($urandom), 0, DW'($urandom), 100, 100, 20, -1, -1);
        repeat (15) tick();
        checks++;
        if (aw_rx !== MAX_OUTST || b_rx !== 0) begin
            errors++;
            $display("FAIL max_outst_stall: aw=%0d b=%0d expected aw=%0d b=0", aw_rx, b_rx, MAX_OUTST);
        end
        finish_cmd("max_outst");
    endtask

    task automatic test_mixed_resp();
        start_cmd(6, AW'($urandom), int'($urandom_range(0, 3)), DW'($urandom), 100, 100, 0, 2, 5);
        finish_cmd("mixed");
    endtask

    task automatic test_random_stalls();
        for (int r = 0; r < 4; r++) begin
            start_cmd(int'($urandom_range(1, 10)), AW'($urandom), int'($urandom_range(0, 7)), DW'($urandom),
                      50, 50, int'($urandom_range(0, 10)), int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
            finish_cmd("random");
        end
    endtask

    task automatic test_zero_txn();
        start_cmd(0, AW'($urandom), 2, DW'($urandom), 100, 100, 0, -1, -1);
        finish_cmd("zero");
    endtask

    task automatic test_wrap();
        start_cmd(3, 32'hFFFF_FFF0, 3, DW'($urandom), 100, 100, 0, -1, -1);
        finish_cmd("wrap");
        checks++;
        if (awa_q.size() < 2 || awa_q[1] !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_addr1: got %h expected 00000000", (awa_q.size() < 2) ? 32'hx : awa_q[1]);
        end
    endtask

    task automatic test_back_to_back();
        start_cmd(4, AW'($urandom), 1, DW'($urandom), 100, 100, 0, -1, -1);
        tick();
        start = 1'b1;
        num_txn = 16'd9;
        tick();
        start = 1'b0;
        finish_cmd("back_to_back");
        for (int k = 0; k < awc_q.size(); k++) begin
            checks++;
            if (awc_q[k] !== cyc0 + 1 + k) begin
                errors++;
                $display("FAIL b2b_aw[%0d]: cycle %0d expected %0d", k, awc_q[k] - cyc0, 1 + k);
            end
        end
        for (int g = 1; g < wc_q.size(); g++) begin
            checks++;
            if (wc_q[g] !== wc_q[0] + g) begin
                errors++;
                $display("FAIL b2b_w[%0d]: cycle %0d expected %0d", g, wc_q[g] - cyc0, wc_q[0] + g - cyc0);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        start_cmd(6, AW'($urandom), 3, DW'($urandom), 100, 100, 0, -1, -1);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.aw_valid, bus.w_valid, bus.b_ready, busy, done, err_cnt, last_resp, bus.aw_addr, bus.aw_id,
             bus.aw_len, bus.aw_size, bus.aw_burst, bus.aw_user, bus.w_data, bus.w_strb, bus.w_last, bus.w_user} !== '0) begin
            errors++;
            $display("FAIL async_reset: aw_valid=%b w_valid=%b b_ready=%b busy=%b aw_addr=%h w_data=%h expected all 0",
                     bus.aw_valid, bus.w_valid, bus.b_ready, busy, bus.aw_addr, bus.w_data);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, done, bus.aw_valid, bus.w_valid, bus.b_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL after_abort: busy/done/aw_valid/w_valid/b_ready=%b expected 00001",
                     {busy, done, bus.aw_valid, bus.w_valid, bus.b_ready});
        end
        start_cmd(2, AW'($urandom), 1, DW'($urandom), 100, 100, 0, -1, -1);
        finish_cmd("after_reset");
    endtask

    initial begin
        clear_sb();
        test_reset();
        test_single();
        test_eight_bursts();
        test_max_outst();
        test_mixed_resp();
        test_zero_txn();
        test_wrap();
        test_back_to_back();
        test_random_stalls();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_wr_burst_gen.md
# axi_wr_burst_gen

Synthesizable AXI4 write-traffic generator with response tracking, used in RAB invalidation and translation benches in place of the behavioural master driver. A single command issues a programmable number of INCR write bursts over the RAB master port, with bounded outstanding transactions and deterministic data. The block also checks every B response and reports completion and an error count.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (power of two, ≥8)
- IW, 10, ID width
- UW, 8, user width
- MAX_OUTST, 4, maximum AW-accepted-but-B-not-received transactions (≥1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  command strobe; sampled only in IDLE
- num_txn_i  in  16  number of bursts to issue
- base_addr_i  in  AW  address of burst 0
- len_i  in  8  AXI len (beats−1), applied to every burst
- id_i  in  IW  ID for all bursts; expected B ID
- user_i  in  UW  driven on aw_user and w_user
- data_seed_i  in  DW  data of global beat 0
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse
- err_cnt_o  out  16  count of bad B responses, saturating
- last_resp_o  out  2  b_resp of most recent B handshake
- aw_id/aw_addr/aw_len/aw_size/aw_burst/aw_user  out  IW/AW/8/3/2/UW  AW payload
- aw_valid out 1; aw_ready in 1
- w_data/w_strb/w_last/w_user  out  DW/DW/8/1/UW  W payload
- w_valid out 1; w_ready in 1
- b_id/b_resp/b_user  in  IW/2/UW  B payload
- b_valid in 1; b_ready out 1

## Operation
- FSM: IDLE → RUN on start_i; RUN → DONE when B count == latched num_txn; DONE → IDLE unconditionally (1 cycle, done_o=1).
- start_i in IDLE latches all command inputs and clears err_cnt_o, last_resp_o, and all counters. start_i outside IDLE is ignored.
- num_txn_i=0: RUN → DONE on the next cycle; no AW or W is issued.
- AW engine: burst k has aw_addr = base + k·(len+1)·(DW/8), computed modulo 2^AW (wraps silently). aw_size = log2(DW/8), aw_burst = INCR (2'b01), aw_id = id_i.
- AW stall: no new aw_valid while outstanding == MAX_OUTST or aw_sent == num_txn.
- W engine: sends bursts in AW order. Beats of burst k start only when aw_sent > k. w_data = seed + global beat index (mod 2^DW). w_strb is all ones. w_last is set on beat len of each burst.
- outstanding: +1 on AW handshake, −1 on B handshake; simultaneous events leave it unchanged. A B with outstanding=0 is counted as an error and does not decrement.
- b_ready=1 in every state out of reset; stray B in IDLE/DONE updates err_cnt_o only.
- B check: err_cnt_o increments if b_resp≠OKAY or b_id≠id_i, saturating at 16'hFFFF. last_resp_o is updated on every B handshake.
- AXI rules: once valid is raised, payload and valid stay stable until ready. Valid is never dropped without a handshake.

## Timing
- Reset values: aw_valid=0, w_valid=0, b_ready=0 during reset then 1, busy_o=0, done_o=0, err_cnt_o=0, last_resp_o=0, and all payload outputs 0.
- start_i at cycle 0 → busy_o=1 and aw_valid=1 at cycle 1 (registered).
- Back-to-back AW: one per cycle while aw_ready=1 and the stall conditions are clear.
- First W beat: cycle after the AW-0 handshake at the earliest. W beats are back-to-back under w_ready=1, including across burst boundaries.
- done_o asserts the cycle after the final counted B handshake. busy_o drops in the same cycle as done_o.
- Async reset mid-RUN: all valids drop immediately and the FSM returns to IDLE. There is no drain; in-flight transactions are abandoned.

## Test plan
- Single burst, num_txn=1, len=0, seed=32'hcafebabe, ready/B OKAY always → one AW at base, w_data=cafebabe, w_last=1, done_o one cycle after B, err_cnt=0.
- num_txn=8, len=3, base=32'h1000, DW=32 → aw_addr 1000,1010,…,1070. Data runs seed..seed+31. w_last on every 4th beat. Exactly 8 B accepted.
- MAX_OUTST=4, slave withholds B for 20 cycles → exactly 4 AW handshakes, aw_valid held high, no 5th AW until the first B arrives.
- Mixed responses: B SLVERR on txn 2, wrong b_id on txn 5, num_txn=6 → err_cnt_o=2 and last_resp_o=OKAY at done.
- Random aw_ready/w_ready stalls (50%) → payload stable while valid and not ready. Beat count per burst = len+1. Done after the last B.
- Edge cases: num_txn=0 → done_o at cycle 2 with no traffic. Address wrap with base=32'hFFFF_FFF0 and len=3 gives burst 1 at 32'h0000_0000. rst_ni low mid-burst drops all outputs to reset values asynchronously.
